// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM handshake state and
// the memory arbiter's FSM/grant encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Two-port (instruction/data) arbiter onto a single RAM port; alternates
// between sides on contention and requires one IDLE cycle between grants.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUID = 0
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate
);

  // CPUID carries no logic; it only identifies the core instance.
  if (CPUID < 0) begin : g_cpuid_invalid
  end

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;

  logic d_req;
  logic ram_done;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= INSTR;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        // Data wins unless it was the last side served and instr is waiting.
        if (d_req)
          state_d = (last_grant_q == DATA && iREN) ? IGRANT : DGRANT;
        else if (iREN)
          state_d = IGRANT;
      end
      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_done) begin
          state_d      = IDLE;
          last_grant_d = INSTR;
        end
      end
      DGRANT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else if (ram_done) begin
          state_d      = IDLE;
          last_grant_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (iREN && ram_done) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (d_req && ram_done) begin
          dwait = 1'b0;
          if (!dWEN)
            dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter: grant order, latency,
// write path, ERROR hold, requester abort and asynchronous reset.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  int unsigned n_checks;
  int unsigned n_errors;

  memory_arbiter #(.CPUID(0)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".iwait"},    {31'd0, iwait},  32'd1);
    check({tag, ".dwait"},    {31'd0, dwait},  32'd1);
    check({tag, ".iload"},    iload,           32'd0);
    check({tag, ".dload"},    dload,           32'd0);
    check({tag, ".ramREN"},   {31'd0, ramREN}, 32'd0);
    check({tag, ".ramWEN"},   {31'd0, ramWEN}, 32'd0);
    check({tag, ".ramaddr"},  ramaddr,         32'd0);
    check({tag, ".ramstore"}, ramstore,        32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    settle();
    check_reset_outputs("rst");
    tick();
    nRST = 1'b1;
  endtask

  initial begin
    logic [1:0] order [4];
    n_checks = 0;
    n_errors = 0;
    iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE; nRST = 1'b1;
    #2;
    do_reset();

    // Instruction read: two BUSY cycles, then ACCESS
    iREN = 1; iaddr = 32'h0000_0040;
    settle();
    check("ird.idle_ramREN", {31'd0, ramREN}, 32'd0);
    check("ird.idle_iwait",  {31'd0, iwait},  32'd1);
    tick();
    ramstate = BUSY; settle();
    check("ird.ramREN",  {31'd0, ramREN}, 32'd1);
    check("ird.ramaddr", ramaddr,         32'h0000_0040);
    check("ird.busy1",   {31'd0, iwait},  32'd1);
    tick(); settle();
    check("ird.busy2",   {31'd0, iwait},  32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'h2002_0001; settle();
    check("ird.iwait",   {31'd0, iwait},  32'd0);
    check("ird.iload",   iload,           32'h2002_0001);
    check("ird.dwait",   {31'd0, dwait},  32'd1);
    check("ird.dload",   dload,           32'd0);
    tick();
    ramstate = FREE; settle();
    check("ird.after_iwait", {31'd0, iwait}, 32'd1);
    iREN = 0;
    tick();

    // Simultaneous requests after reset, dREN held: D, I, D, I
    do_reset();
    iREN = 1; iaddr = 32'h0000_0044; dREN = 1; daddr = 32'h0000_0100;
    order[0] = 2'd2; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd1;
    for (int unsigned g = 0; g < 4; g++) begin
      ramstate = FREE; settle();
      check("alt.idle_ramREN", {31'd0, ramREN}, 32'd0);
      tick();
      ramstate = ACCESS; ramload = 32'hA000_0000 + g; settle();
      check("alt.ramREN", {31'd0, ramREN}, 32'd1);
      if (order[g] == 2'd2) begin
        check("alt.d_addr", ramaddr,         32'h0000_0100);
        check("alt.d_wait", {31'd0, dwait},  32'd0);
        check("alt.d_load", dload,           32'hA000_0000 + g);
        check("alt.i_wait", {31'd0, iwait},  32'd1);
        check("alt.i_load", iload,           32'd0);
      end else begin
        check("alt.i_addr", ramaddr,         32'h0000_0044);
        check("alt.i_wait", {31'd0, iwait},  32'd0);
        check("alt.i_load", iload,           32'hA000_0000 + g);
        check("alt.d_wait", {31'd0, dwait},  32'd1);
        check("alt.d_load", dload,           32'd0);
      end
      tick();
    end
    iREN = 0; dREN = 0; ramstate = FREE;
    tick();

    // Data write
    dWEN = 1; daddr = 32'h0000_0200; dstore = 32'hDEAD_BEEF;
    tick();
    ramstate = BUSY; settle();
    check("wr.ramWEN",   {31'd0, ramWEN}, 32'd1);
    check("wr.ramREN",   {31'd0, ramREN}, 32'd0);
    check("wr.ramaddr",  ramaddr,         32'h0000_0200);
    check("wr.ramstore", ramstore,        32'hDEAD_BEEF);
    check("wr.busy_dwait", {31'd0, dwait}, 32'd1);
    tick();
    ramstate = ACCESS; ramload = 32'h1234_5678; settle();
    check("wr.dwait", {31'd0, dwait}, 32'd0);
    check("wr.dload", dload,          32'd0);
    tick();
    dWEN = 0; ramstate = FREE;
    tick();

    // ERROR holds the grant; read+write together issues a write
    dREN = 1; dWEN = 1; daddr = 32'h0000_0300; dstore = 32'h0000_00FF;
    tick();
    ramstate = ERROR;
    for (int unsigned c = 0; c < 10; c++) begin
      settle();
      check("err.dwait",  {31'd0, dwait},  32'd1);
      check("err.ramWEN", {31'd0, ramWEN}, 32'd1);
      check("err.ramREN", {31'd0, ramREN}, 32'd0);
      tick();
    end
    ramstate = ACCESS; settle();
    check("err.done_dwait", {31'd0, dwait}, 32'd0);
    tick();
    dREN = 0; dWEN = 0; ramstate = FREE;
    tick();

    // Instruction aborts before ACCESS: last_grant stays DATA
    iREN = 1; iaddr = 32'h0000_0080;
    tick();
    ramstate = BUSY; settle();
    check("abort.ramREN", {31'd0, ramREN}, 32'd1);
    iREN = 0;
    tick(); settle();
    check("abort.idle_ramREN", {31'd0, ramREN}, 32'd0);
    iREN = 1; dREN = 1; daddr = 32'h0000_0100;
    tick(); settle();
    check("abort.next_is_i", ramaddr, 32'h0000_0080);
    ramstate = ACCESS; ramload = 32'h0BAD_F00D; settle();
    check("abort.iload", iload, 32'h0BAD_F00D);
    tick();
    iREN = 0; ramstate = FREE;

    // Reset during DGRANT (dREN still high, last_grant INSTR)
    tick();
    ramstate = BUSY; settle();
    check("mid.ramREN", {31'd0, ramREN}, 32'd1);
    #2;
    nRST = 1'b0; ramstate = ACCESS; ramload = 32'h5555_AAAA;
    settle();
    check_reset_outputs("mid");
    tick();
    nRST = 1'b1; settle();
    check("mid.post_dwait",  {31'd0, dwait},  32'd1);
    check("mid.post_ramREN", {31'd0, ramREN}, 32'd0);
    ramstate = BUSY;
    tick(); settle();
    check("mid.regrant_addr", ramaddr, 32'h0000_0100);
    check("mid.regrant_dwait", {31'd0, dwait}, 32'd1);
    ramstate = ACCESS; settle();
    check("mid.done_dwait", {31'd0, dwait}, 32'd0);
    check("mid.done_dload", dload, 32'h5555_AAAA);
    tick();
    dREN = 0; ramstate = FREE;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000ns");
    $fatal(1);
  end

endmodule
